// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous memory port between instruction fetch (I)
//            and load/store (D), one transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LATENCY     = 1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic [31:0]           d_rdata,
    output logic                  d_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0]            C_CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] C_WORD_MASK = ~(ADDR_WIDTH'(3));

    state_t                state_q, state_d;
    logic                  owner_d_q, owner_d_d;       // 1: D owns the port
    logic                  last_d_q, last_d_d;         // 1: last grant went to D
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [3:0]            cnt_q, cnt_d;

    logic w_grant_d;
    logic w_done;

    // D wins if alone, or on conflict when fixed priority or it is D's turn.
    assign w_grant_d = d_req && (!i_req || !ROUND_ROBIN || !last_d_q);

    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d_d = w_grant_d;
                    last_d_d  = w_grant_d;
                    addr_d    = (w_grant_d ? d_addr : i_addr) & C_WORD_MASK;
                    wdata_d   = w_grant_d ? d_wdata : 32'd0;
                    wmask_d   = w_grant_d ? d_wmask : 4'd0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = C_CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            cnt_q     <= cnt_d;
        end
    end

    assign w_done    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign i_done    = w_done && !owner_d_q;
    assign d_done    = w_done && owner_d_q;
    assign i_rdata   = i_done ? mem_rdata : 32'd0;
    assign d_rdata   = d_done ? mem_rdata : 32'd0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rstrb = (state_q == ST_ISSUE) && (wmask_q == 4'd0);
    assign mem_wmask = (state_q == ST_ISSUE) ? wmask_q : 4'd0;

endmodule
`default_nettype wire
